lcd_16x2_8bit_reader: RTL and testbench

- Read-side companion to the 16x2 LCD 8-bit write driver. It runs HD44780-style read cycles (RW=1) on a 16x2 character LCD.
- Two read types: busy-flag/address-counter read (RS=0) and data-RAM read (RS=1).
- Optional busy-flag polling repeats BF reads until the LCD is ready, with a timeout.
- Sits beside the write driver under the LCD controller FSM, which muxes rs/en and owns the bus tristate using bus_req.

---
 rtl/lcd_pkg.sv | 29 ++
 rtl/lcd_delay_counter.sv | 26 ++
 rtl/lcd_16x2_8bit_reader.sv | 147 ++++++++++++++
 tb/tb_lcd_16x2_8bit_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state encodings, bus constants and timing defaults for the LCD drivers
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_SETUP   = 3'b001,
        ST_EN_HIGH = 3'b010,
        ST_HOLD    = 3'b011,
        ST_DONE    = 3'b100
    } lcd_state_t;

    localparam logic RS_CMD   = 1'b0;
    localparam logic RS_DATA  = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam int BF_BIT = 7;

    localparam int DEF_T_SETUP  = 2;
    localparam int DEF_T_EN     = 25000;
    localparam int DEF_T_HOLD   = 25000;
    localparam int DEF_POLL_MAX = 1000;

    // Terminal count for a phase of p cycles; zero-length phases are stretched to one cycle.
    function automatic logic [15:0] last_count(input int unsigned p);
        return (p == 0) ? 16'd0 : 16'(p - 1);
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// rtl/lcd_delay_counter.sv - 16-bit phase delay counter with clear, enable and run-time terminal count
module lcd_delay_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] last,
    output logic        tc
);

    logic [15:0] cnt;

    // Holds at the terminal count rather than wrapping inside a phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 16'd0;
        end else if (clr) begin
            cnt <= 16'd0;
        end else if (en && !tc) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign tc = (cnt >= last);

endmodule

// File: rtl/lcd_16x2_8bit_reader.sv
// rtl/lcd_16x2_8bit_reader.sv - HD44780-style read cycle engine with optional busy-flag polling
module lcd_16x2_8bit_reader
    import lcd_pkg::*;
#(
    parameter int T_SETUP  = DEF_T_SETUP,
    parameter int T_EN     = DEF_T_EN,
    parameter int T_HOLD   = DEF_T_HOLD,
    parameter int POLL_MAX = DEF_POLL_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cd,
    input  logic       poll,
    input  logic [7:0] lcd_data_in,
    output logic       rs,
    output logic       rw,
    output logic       en,
    output logic       bus_req,
    output logic       busy,
    output logic [7:0] rd_data,
    output logic       bf,
    output logic [6:0] ac,
    output logic       done_tick,
    output logic       timeout_tick
);

    localparam logic [15:0] SETUP_LAST = last_count(T_SETUP);
    localparam logic [15:0] EN_LAST    = last_count(T_EN);
    localparam logic [15:0] HOLD_LAST  = last_count(T_HOLD);
    localparam logic [16:0] POLL_LIMIT = (POLL_MAX == 0) ? 17'd1 : 17'(POLL_MAX);

    lcd_state_t  state;
    logic        cd_q;
    logic        poll_q;
    logic [15:0] poll_cnt;
    logic [15:0] dly_last;
    logic        dly_clr;
    logic        dly_tc;
    logic        poll_again;
    logic        still_busy;

    always_comb begin
        dly_last = 16'd0;
        case (state)
            ST_SETUP:   dly_last = SETUP_LAST;
            ST_EN_HIGH: dly_last = EN_LAST;
            ST_HOLD:    dly_last = HOLD_LAST;
            default:    dly_last = 16'd0;
        endcase
    end

    // Every timed phase ends on tc, so clearing on tc makes the counter start at 0 on entry.
    assign dly_clr = (state == ST_IDLE) || (state == ST_DONE) || dly_tc;

    lcd_delay_counter u_delay (
        .clk  (clk),
        .rst  (rst),
        .clr  (dly_clr),
        .en   (1'b1),
        .last (dly_last),
        .tc   (dly_tc)
    );

    // poll_cnt counts repeat reads, so reads done so far is poll_cnt + 1.
    assign still_busy = poll_q && (cd_q == RS_CMD) && rd_data[BF_BIT];
    assign poll_again = still_busy && ((17'(poll_cnt) + 17'd1) < POLL_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cd_q         <= 1'b0;
            poll_q       <= 1'b0;
            poll_cnt     <= 16'd0;
            rs           <= 1'b0;
            rw           <= 1'b0;
            en           <= 1'b0;
            bus_req      <= 1'b0;
            busy         <= 1'b0;
            rd_data      <= 8'd0;
            bf           <= 1'b0;
            ac           <= 7'd0;
            done_tick    <= 1'b0;
            timeout_tick <= 1'b0;
        end else begin
            done_tick    <= 1'b0;
            timeout_tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cd_q     <= cd;
                        poll_q   <= poll;
                        poll_cnt <= 16'd0;
                        rs       <= cd;
                        rw       <= RW_READ;
                        bus_req  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (dly_tc) begin
                        en    <= 1'b1;
                        state <= ST_EN_HIGH;
                    end
                end
                ST_EN_HIGH: begin
                    if (dly_tc) begin
                        en      <= 1'b0;
                        rd_data <= lcd_data_in;
                        if (cd_q == RS_CMD) begin
                            bf <= lcd_data_in[BF_BIT];
                            ac <= lcd_data_in[6:0];
                        end else begin
                            bf <= 1'b0;
                            ac <= 7'd0;
                        end
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (dly_tc) begin
                        if (poll_again) begin
                            if (17'(poll_cnt) < POLL_LIMIT) begin
                                poll_cnt <= poll_cnt + 16'd1;
                            end
                            state <= ST_SETUP;
                        end else begin
                            done_tick    <= 1'b1;
                            timeout_tick <= still_busy;
                            state        <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    rs      <= 1'b0;
                    rw      <= RW_WRITE;
                    bus_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_16x2_8bit_reader.sv
// tb/tb_lcd_16x2_8bit_reader.sv - scoreboard bench for the LCD read cycle engine
module tb_lcd_16x2_8bit_reader;

    localparam int TS  = 1;
    localparam int TE  = 4;
    localparam int TH  = 2;
    localparam int PM  = 3;
    localparam int PER = TS + TE + TH;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       cd = 1'b0;
    logic       poll = 1'b0;
    logic [7:0] lcd_data_in = 8'd0;
    logic       rs, rw, en, bus_req, busy, bf, done_tick, timeout_tick;
    logic [7:0] rd_data;
    logic [6:0] ac;

    typedef struct {
        logic [7:0] rd;
        logic       bf;
        logic [6:0] ac;
        logic       to;
        int         n;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] dlist[8];
    int         dlen = 1;
    int         didx = 0;
    int         cyc = 0;
    int         pulses = 0;
    logic       en_d = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    lcd_16x2_8bit_reader #(
        .T_SETUP (TS),
        .T_EN    (TE),
        .T_HOLD  (TH),
        .POLL_MAX(PM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cd          (cd),
        .poll        (poll),
        .lcd_data_in (lcd_data_in),
        .rs          (rs),
        .rw          (rw),
        .en          (en),
        .bus_req     (bus_req),
        .busy        (busy),
        .rd_data     (rd_data),
        .bf          (bf),
        .ac          (ac),
        .done_tick   (done_tick),
        .timeout_tick(timeout_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: a read sequence ends at the first non-busy byte or after PM reads, each read costs PER cycles.
    task automatic launch(input logic c, input logic p, input logic [7:0] d[8], input int len,
                          input bit expect_it);
        int         n;
        logic [7:0] last;
        exp_t       e;
        n      = (c || !p) ? 1 : ((len < PM) ? len : PM);
        last   = d[n-1];
        e.rd   = last;
        e.bf   = c ? 1'b0 : last[7];
        e.ac   = c ? 7'd0 : last[6:0];
        e.to   = !c && p && last[7];
        e.n    = n;
        e.cyc  = cyc + 1 + PER * n;
        if (expect_it) sb.push_back(e);
        dlist = d;
        dlen  = len;
        didx  = 0;
        cd    = c;
        poll  = p;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = done_tick;
        end
        if (!seen) check("done_wait_expired", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (!rst) begin
                        pulses = 0;
                    end else begin
                        if (en && !en_d) begin
                            pulses++;
                            lcd_data_in = dlist[(didx < dlen) ? didx : dlen - 1];
                            didx++;
                        end
                        if (timeout_tick && !done_tick) check("timeout_without_done", 1, 0);
                        if (done_tick) begin
                            if (sb.size() == 0) begin
                                check("unexpected_done", 1, 0);
                            end else begin
                                e = sb.pop_front();
                                check("rd_data", rd_data, e.rd);
                                check("bf", bf, e.bf);
                                check("ac", ac, e.ac);
                                check("timeout_tick", timeout_tick, e.to);
                                check("en_pulses", pulses, e.n);
                                check("done_cycle", cyc, e.cyc);
                            end
                            pulses = 0;
                        end
                    end
                    en_d = en;
                end
            end
            begin : stimulus
                logic [7:0] d[8];
                int         c0;
                logic       rc, rp;
                int         nb, len;

                repeat (3) @(negedge clk);
                check("rst_rs", rs, 0);
                check("rst_rw", rw, 0);
                check("rst_en", en, 0);
                check("rst_bus_req", bus_req, 0);
                check("rst_busy", busy, 0);
                check("rst_done_tick", done_tick, 0);
                check("rst_timeout_tick", timeout_tick, 0);
                check("rst_rd_data", rd_data, 0);
                check("rst_bf_ac", {bf, ac}, 0);
                rst = 1'b1;
                @(negedge clk);

                // Data read with cycle-exact strobe checks; stray starts in EN_HIGH and DONE must be ignored.
                for (int i = 0; i < 8; i++) d[i] = 8'h41;
                c0 = cyc;
                launch(1'b1, 1'b0, d, 1, 1'b1);
                for (int j = 1; j <= 9; j++) begin
                    if (j > 1) @(negedge clk);
                    if (j == 1) begin
                        check("rs_setup", rs, 1);
                        check("rw_setup", rw, 1);
                        check("bus_req_setup", bus_req, 1);
                    end
                    check($sformatf("en_cycle_k%0d", j), en, (j >= 2 && j <= 5) ? 1 : 0);
                    if (j == 3) begin
                        cd    = 1'b0;
                        poll  = 1'b1;
                        start = 1'b1;
                    end
                    if (j == 4) start = 1'b0;
                    if (j == 8) start = 1'b1;
                    if (j == 9) begin
                        check("rw_after_done", rw, 0);
                        check("busy_after_done", busy, 0);
                    end
                end
                check("cycle_after_done", cyc, c0 + 9);
                for (int i = 0; i < 8; i++) d[i] = 8'h8A;
                launch(1'b0, 1'b0, d, 1, 1'b1);
                wait_done();

                d[0] = 8'h80;
                d[1] = 8'h05;
                launch(1'b0, 1'b1, d, 2, 1'b1);
                wait_done();

                for (int i = 0; i < 8; i++) d[i] = 8'hFF;
                launch(1'b0, 1'b1, d, 4, 1'b1);
                wait_done();

                // Reset during EN_HIGH aborts without a done pulse.
                for (int i = 0; i < 8; i++) d[i] = 8'h5C;
                launch(1'b1, 1'b0, d, 1, 1'b0);
                @(negedge clk);
                @(negedge clk);
                check("en_before_abort", en, 1);
                rst = 1'b0;
                #1;
                check("abort_pins", {en, rw, rs, bus_req, busy}, 0);
                check("abort_rd_data", rd_data, 0);
                repeat (3) @(negedge clk);
                check("abort_done_tick", done_tick, 0);
                rst = 1'b1;
                @(negedge clk);
                for (int i = 0; i < 8; i++) d[i] = 8'h6B;
                launch(1'b1, 1'b0, d, 1, 1'b1);
                wait_done();

                for (int t = 0; t < 30; t++) begin
                    rc = 1'($urandom % 2);
                    rp = 1'($urandom % 2);
                    nb = $urandom_range(0, 4);
                    for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
                    for (int i = 0; i < nb; i++) d[i][7] = 1'b1;
                    d[nb][7] = 1'b0;
                    len = (rc || !rp) ? 1 : nb + 1;
                    launch(rc, rp, d, len, 1'b1);
                    wait_done();
                end

                repeat (5) @(negedge clk);
                check("scoreboard_drained", sb.size(), 0);
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
